// File: rtl/fp16_mul_issue_ctrl.sv
// Credit-gated issue front-end and in-order result FIFO for a fixed-latency, non-stallable fp16 multiplier.
// Results appear MUL_LATENCY+1 cycles after fire; in_ready falls once in-flight plus buffered results reach FIFO_DEPTH.
module fp16_mul_issue_ctrl #(
  parameter int MUL_LATENCY = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int CNT_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic [15:0]      mul_a,
  output logic [15:0]      mul_b,
  input  logic [15:0]      mul_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_nan,
  output logic [CNT_W-1:0] inflight,
  output logic [CNT_W-1:0] occupancy,
  output logic             overflow_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [MUL_LATENCY-1:0] vld_q, vld_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       inflight_q, inflight_d;
  logic [CNT_W-1:0]       occupancy_q, occupancy_d;
  logic                   overflow_err_q, overflow_err_d;
  logic [15:0]            mem_q [FIFO_DEPTH];
  logic [15:0]            mem_d [FIFO_DEPTH];

  logic [CNT_W:0]         credits_used;
  logic                   fire;
  logic                   push;
  logic                   pop;

  // Credits come only from registered counts so in_ready never depends on out_ready.
  always_comb begin
    credits_used = {1'b0, inflight_q} + {1'b0, occupancy_q};
    in_ready     = ~rst & (credits_used < (CNT_W+1)'(FIFO_DEPTH));
    fire         = in_valid & in_ready;
    mul_a        = fire ? in_a : 16'h0000;
    mul_b        = fire ? in_b : 16'h0000;
  end

  always_comb begin
    out_valid    = ~rst & (occupancy_q != '0);
    out_data     = mem_q[rd_ptr_q];
    out_nan      = out_valid & (&out_data[14:10]) & (|out_data[9:0]);
    push         = vld_q[MUL_LATENCY-1];
    pop          = out_valid & out_ready;
    inflight     = inflight_q;
    occupancy    = occupancy_q;
    overflow_err = overflow_err_q;
  end

  // The valid line mirrors the multiplier pipeline; its last tap qualifies mul_out.
  always_comb begin
    vld_d          = {vld_q[MUL_LATENCY-2:0], fire};
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    inflight_d     = inflight_q + CNT_W'(fire) - CNT_W'(push);
    occupancy_d    = occupancy_q + CNT_W'(push) - CNT_W'(pop);
    overflow_err_d = overflow_err_q;
    mem_d          = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = mul_out;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop && (occupancy_q == CNT_W'(FIFO_DEPTH))) begin
      overflow_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q          <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      inflight_q     <= '0;
      occupancy_q    <= '0;
      overflow_err_q <= 1'b0;
    end else begin
      vld_q          <= vld_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      inflight_q     <= inflight_d;
      occupancy_q    <= occupancy_d;
      overflow_err_q <= overflow_err_d;
    end
  end

  // Result storage holds no state that matters after reset, so it is left unreset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
